cacheline_adaptor: RTL and testbench
====================================

Name: cacheline_adaptor

Overview:
- Responder end of the cache-to-physical-memory line interface.
- Accepts a 256-bit line read or write from the cache miss/writeback path and services it as a 4-beat, 64-bit burst on the main-memory port.
- Sits between the last-level cache and burst DRAM. Presents a single-cycle line-response handshake to the cache.

Parameters:
- s_offset, 5, line offset bits; burst addresses are line-aligned on 2**s_offset bytes.
- s_line, 256, line width in bits.
- s_beat, 64, burst beat width in bits.
- num_beats, s_line/s_beat (4), beats per line.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- pmem_read  input  1  line read request; held until pmem_resp
- pmem_write  input  1  line write request; held until pmem_resp
- pmem_address  input  32  line address
- pmem_wdata  input  256  write line
- pmem_rdata  output  256  read line; valid when pmem_resp is high
- pmem_resp  output  1  one-cycle completion pulse
- burst_read  output  1  burst read request
- burst_write  output  1  burst write request
- burst_address  output  32  line-aligned burst address
- burst_wdata  output  64  current write beat
- burst_rdata  input  64  current read beat
- burst_resp  input  1  beat transferred this cycle

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous, active-high, on rst.
- States: IDLE, READ, WRITE, DONE. State, beat counter, address latch, line buffer and pmem_rdata are all registered.
- Reset values: state=IDLE, counter=0, pmem_rdata=0, pmem_resp=0, burst_read=0, burst_write=0, burst_address=0, burst_wdata=0.
- Reset in any state, including mid-burst: return to IDLE next edge and drop burst_read/burst_write. The memory burst in flight is abandoned; no pmem_resp is issued.
- IDLE, request sampled on a clock edge:
  - pmem_write=1: go to WRITE. Latch {pmem_address[31:s_offset], s_offset'b0} into the address register. Latch pmem_wdata into the line buffer. Set counter=0.
  - pmem_write=0, pmem_read=1: go to READ, latch the address, set counter=0.
  - pmem_read and pmem_write both high: write has priority; read is not serviced.
- READ:
  - burst_read=1, burst_address=latched address.
  - On each cycle with burst_resp=1, store burst_rdata into buffer bits [count*64 +: 64] and increment the counter. Beat 0 is line bits [63:0].
  - Cycles with burst_resp=0 insert wait states; counter holds.
  - On the beat with count=num_beats-1: go to DONE, and pmem_rdata loads the full buffer including that final beat.
- WRITE:
  - burst_write=1, burst_address=latched address, burst_wdata=buffer[count*64 +: 64] (combinational from the counter).
  - On each burst_resp=1, increment the counter. After the last beat, go to DONE.
- DONE:
  - pmem_resp=1 for exactly one cycle; burst_read=burst_write=0. Next state is IDLE.
  - pmem_rdata holds its value until the next read completes. Writes do not modify it.
- Request still high in the cycle after DONE (i.e. in IDLE) is treated as a new request. The cache must deassert, or issue its next request, on the edge where it sees pmem_resp.
- burst_resp in IDLE or DONE is ignored.
- Counter is log2(num_beats) bits and never wraps inside a burst.
- Changes to pmem_address/pmem_wdata after acceptance have no effect.
- Minimum latency with burst_resp high every cycle:
  - request accepted at edge t; burst_* asserted t+1..t+4; pmem_resp high in cycle t+5.
  - Total of 6 cycles from request to response.

Test Plan:
- Read, zero wait: pmem_read, pmem_address=0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles.
  -> burst_address=0x0000_1220 during beats.
  -> pmem_rdata=0x44..44_33..33_22..22_11..11 with pmem_resp high on the 6th cycle.
  -> pmem_resp low before and after that cycle.
- Write, wait states: pmem_write, pmem_wdata=0xDDDD..._CCCC..._BBBB..._AAAA...; burst_resp asserted on cycles 2,3,5,8 of the burst.
  -> burst_wdata = AAAA..., BBBB..., CCCC..., DDDD... in order, each held until its resp.
  -> pmem_resp exactly once, the cycle after the 4th resp.
- Simultaneous read+write in IDLE: both high, address 0x8000_0040.
  -> WRITE burst only, with burst_write=1 and burst_read=0 throughout.
  -> pmem_rdata unchanged.
- Reset mid-read after 2 beats: rst high for 1 cycle.
  -> Next cycle burst_read=0, pmem_resp=0, pmem_rdata=0.
  -> A following read completes normally with correct data.
- Back-to-back: writeback to 0x100 then read of 0x200 issued the cycle after the first pmem_resp.
  -> Two bursts in order, one pmem_resp each.
  -> Read data is correct and not corrupted by the write buffer.
- Spurious burst_resp in IDLE with no request.
  -> No state change, pmem_resp stays 0.

Source files
------------

// File: rtl/cacheline_adaptor.sv
// Cache-side line port to 64-bit burst memory adaptor: one 256-bit line read or write
// is serviced as a 4-beat burst, then acknowledged with a single-cycle pmem_resp.
module cacheline_adaptor #(
    parameter int s_offset = 5,
    parameter int s_line   = 256,
    parameter int s_beat   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [31:0]       pmem_address,
    input  logic [s_line-1:0] pmem_wdata,
    output logic [s_line-1:0] pmem_rdata,
    output logic              pmem_resp,
    output logic              burst_read,
    output logic              burst_write,
    output logic [31:0]       burst_address,
    output logic [s_beat-1:0] burst_wdata,
    input  logic [s_beat-1:0] burst_rdata,
    input  logic              burst_resp
);

    localparam int num_beats = s_line / s_beat;
    localparam int CNT_W     = $clog2(num_beats);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         addr_q, addr_d;
    logic [s_line-1:0]   buf_q, buf_d;
    logic [s_line-1:0]   rdata_q, rdata_d;
    logic                last_beat;

    assign last_beat = (cnt_q == CNT_W'(num_beats - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        buf_d   = buf_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                // Write wins when both requests are raised together.
                if (pmem_write) begin
                    state_d = WRITE;
                    addr_d  = {pmem_address[31:s_offset], {s_offset{1'b0}}};
                    buf_d   = pmem_wdata;
                    cnt_d   = '0;
                end else if (pmem_read) begin
                    state_d = READ;
                    addr_d  = {pmem_address[31:s_offset], {s_offset{1'b0}}};
                    cnt_d   = '0;
                end
            end
            READ: begin
                if (burst_resp) begin
                    buf_d[int'(cnt_q)*s_beat +: s_beat] = burst_rdata;
                    if (last_beat) begin
                        state_d = DONE;
                        rdata_d = buf_d;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            WRITE: begin
                if (burst_resp) begin
                    if (last_beat) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
        end
    end

    // Line buffer is pure data; its contents only matter once a request has loaded it.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign pmem_rdata    = rdata_q;
    assign pmem_resp     = (state_q == DONE);
    assign burst_read    = (state_q == READ);
    assign burst_write   = (state_q == WRITE);
    assign burst_address = addr_q;
    assign burst_wdata   = (state_q == WRITE) ? buf_q[int'(cnt_q)*s_beat +: s_beat] : '0;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: reset, reads, writes with wait states,
// read/write collision, mid-burst reset, back-to-back requests, stray burst_resp.
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic         pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic         burst_read, burst_write;
    logic [31:0]  burst_address;
    logic [63:0]  burst_wdata;
    logic [63:0]  burst_rdata;
    logic         burst_resp;

    int n_tests = 0;
    int n_fail  = 0;

    cacheline_adaptor dut (
        .clk           (clk),
        .rst           (rst),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .pmem_rdata    (pmem_rdata),
        .pmem_resp     (pmem_resp),
        .burst_read    (burst_read),
        .burst_write   (burst_write),
        .burst_address (burst_address),
        .burst_wdata   (burst_wdata),
        .burst_rdata   (burst_rdata),
        .burst_resp    (burst_resp)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives four zero-wait beats of a read burst and checks the bus each beat.
    task automatic read_beats(input logic [255:0] line, input logic [31:0] exp_addr);
        for (int i = 0; i < 4; i++) begin
            check("rd_burst_read", burst_read, 1'b1);
            check("rd_burst_write", burst_write, 1'b0);
            check("rd_addr", burst_address, exp_addr);
            check("rd_resp_low", pmem_resp, 1'b0);
            burst_resp  = 1'b1;
            burst_rdata = line[i*64 +: 64];
            step();
        end
    endtask

    task automatic write_beats(input logic [255:0] line, input logic [31:0] exp_addr);
        for (int i = 0; i < 4; i++) begin
            check("wr_burst_write", burst_write, 1'b1);
            check("wr_burst_read", burst_read, 1'b0);
            check("wr_addr", burst_address, exp_addr);
            check("wr_wdata", burst_wdata, line[i*64 +: 64]);
            check("wr_resp_low", pmem_resp, 1'b0);
            burst_resp = 1'b1;
            step();
        end
    endtask

    logic [255:0] line_a, line_w, line_w2, line_r2, line_w3, line_r3, line_p;
    int           nresp;

    initial begin
        line_a  = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        line_w  = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
        line_w2 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
        line_p  = {64'hBAD0_BAD0_BAD0_BAD0, 64'hBAD1_BAD1_BAD1_BAD1, 64'hBAD2_BAD2_BAD2_BAD2, 64'hBAD3_BAD3_BAD3_BAD3};
        line_r2 = {64'h0000_0000_0000_0004, 64'h0000_0000_0000_0003, 64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001};
        line_w3 = {64'hAAAA_0003_AAAA_0003, 64'hAAAA_0002_AAAA_0002, 64'hAAAA_0001_AAAA_0001, 64'hAAAA_0000_AAAA_0000};
        line_r3 = {64'h5A5A_0003_5A5A_0003, 64'h5A5A_0002_5A5A_0002, 64'h5A5A_0001_5A5A_0001, 64'h5A5A_0000_5A5A_0000};

        rst = 1'b1; pmem_read = 1'b0; pmem_write = 1'b0; pmem_address = '0;
        pmem_wdata = '0; burst_rdata = '0; burst_resp = 1'b0;
        step(); step();
        check("rst_resp", pmem_resp, 1'b0);
        check("rst_bread", burst_read, 1'b0);
        check("rst_bwrite", burst_write, 1'b0);
        check("rst_baddr", burst_address, 32'h0);
        check("rst_bwdata", burst_wdata, 64'h0);
        check("rst_rdata", pmem_rdata, 256'h0);
        rst = 1'b0;
        step();

        // Stray burst_resp while idle
        burst_resp = 1'b1; burst_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            check("spur_resp", pmem_resp, 1'b0);
            check("spur_bread", burst_read, 1'b0);
            check("spur_bwrite", burst_write, 1'b0);
        end
        burst_resp = 1'b0;
        check("spur_rdata", pmem_rdata, 256'h0);

        // Read, zero wait states
        pmem_read = 1'b1; pmem_address = 32'h0000_1234;
        step();
        read_beats(line_a, 32'h0000_1220);
        check("rd1_resp", pmem_resp, 1'b1);
        check("rd1_rdata", pmem_rdata, line_a);
        check("rd1_bread_off", burst_read, 1'b0);
        pmem_read = 1'b0; burst_resp = 1'b0;
        step();
        check("rd1_resp_after", pmem_resp, 1'b0);
        check("rd1_rdata_hold", pmem_rdata, line_a);

        // Write with burst_resp only on burst cycles 2,3,5,8
        pmem_write = 1'b1; pmem_wdata = line_w; pmem_address = 32'h0000_0080;
        step();
        pmem_wdata = '0;
        nresp = 0;
        for (int c = 1; c <= 8; c++) begin
            check("wr_wait_bwrite", burst_write, 1'b1);
            check("wr_wait_wdata", burst_wdata, line_w[nresp*64 +: 64]);
            check("wr_wait_resp", pmem_resp, 1'b0);
            burst_resp = (c == 2 || c == 3 || c == 5 || c == 8);
            if (burst_resp) nresp++;
            step();
        end
        burst_resp = 1'b0;
        check("wr_done_resp", pmem_resp, 1'b1);
        check("wr_rdata_kept", pmem_rdata, line_a);
        pmem_write = 1'b0;
        step();
        check("wr_resp_after", pmem_resp, 1'b0);

        // Read and write both high: write only
        pmem_read = 1'b1; pmem_write = 1'b1; pmem_address = 32'h8000_0040; pmem_wdata = line_w2;
        step();
        write_beats(line_w2, 32'h8000_0040);
        check("rw_resp", pmem_resp, 1'b1);
        check("rw_rdata_kept", pmem_rdata, line_a);
        pmem_read = 1'b0; pmem_write = 1'b0; burst_resp = 1'b0;
        step();
        check("rw_bread_idle", burst_read, 1'b0);
        check("rw_resp_after", pmem_resp, 1'b0);

        // Reset after two beats of a read
        pmem_read = 1'b1; pmem_address = 32'h0000_0300;
        step();
        for (int i = 0; i < 2; i++) begin
            burst_resp = 1'b1; burst_rdata = line_p[i*64 +: 64];
            step();
        end
        check("mid_bread", burst_read, 1'b1);
        rst = 1'b1; pmem_read = 1'b0; burst_resp = 1'b0;
        step();
        check("mrst_bread", burst_read, 1'b0);
        check("mrst_resp", pmem_resp, 1'b0);
        check("mrst_rdata", pmem_rdata, 256'h0);
        rst = 1'b0;
        step();
        check("mrst_idle_resp", pmem_resp, 1'b0);
        pmem_read = 1'b1; pmem_address = 32'h0000_004F;
        step();
        read_beats(line_r2, 32'h0000_0040);
        check("mrst_rd_resp", pmem_resp, 1'b1);
        check("mrst_rd_rdata", pmem_rdata, line_r2);
        pmem_read = 1'b0; burst_resp = 1'b0;
        step();

        // Back-to-back writeback then read
        pmem_write = 1'b1; pmem_address = 32'h0000_0100; pmem_wdata = line_w3;
        step();
        write_beats(line_w3, 32'h0000_0100);
        check("b2b_wr_resp", pmem_resp, 1'b1);
        pmem_write = 1'b0; pmem_read = 1'b1; pmem_address = 32'h0000_0200; pmem_wdata = line_w2;
        step();
        check("b2b_gap_resp", pmem_resp, 1'b0);
        check("b2b_gap_bwrite", burst_write, 1'b0);
        check("b2b_gap_bread", burst_read, 1'b0);
        step();
        read_beats(line_r3, 32'h0000_0200);
        check("b2b_rd_resp", pmem_resp, 1'b1);
        check("b2b_rd_rdata", pmem_rdata, line_r3);
        pmem_read = 1'b0; burst_resp = 1'b0;
        step();
        check("b2b_resp_after", pmem_resp, 1'b0);
        check("b2b_rdata_hold", pmem_rdata, line_r3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
